// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared state encodings and blinker timing constants for period_meter
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_OVERFLOW = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ         = 50000000;
  // One blinker toggle lands every CLK_HZ+1 cycles because its count chain wraps at CLK_HZ.
  localparam int unsigned BLINK_INTERVAL = CLK_HZ + 1;

endpackage

// File: rtl/period_meter_edge_sync.sv
// rtl/period_meter_edge_sync.sv - synchroniser, delay flop and registered edge strobe for sig_in
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_MODE   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   dly;
  logic                   edge_seen;

  always_comb begin
    if (EDGE_MODE) edge_seen = sync_chain[SYNC_STAGES-1] & ~dly;
    else           edge_seen = sync_chain[SYNC_STAGES-1] ^ dly;
  end

  // Strobe is registered so the counter/FSM sees a clean flop output.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_chain <= '0;
      dly        <= 1'b0;
      strobe     <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], sig_in};
      dly        <= sync_chain[SYNC_STAGES-1];
      strobe     <= edge_seen;
    end
  end

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures the cycle spacing between edges of an asynchronous input
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned WIDTH       = 26,
  parameter int unsigned TARGET      = BLINK_INTERVAL,
  parameter int unsigned TOL         = 50,
  parameter bit          EDGE_MODE   = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             in_range,
  output logic             overflow
);

  localparam longint unsigned CNT_MAX_L = (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TARGET_W = WIDTH'(TARGET);
  localparam logic [WIDTH:0]   TOL_W    = (WIDTH+1)'(TOL);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("period_meter: SYNC_STAGES must be at least 2");
  end
  if (64'(TARGET) > CNT_MAX_L || 64'(TOL) > CNT_MAX_L) begin : g_bad_fit
    $error("period_meter: TARGET and TOL must fit in WIDTH bits");
  end

  logic strobe;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_MODE  (EDGE_MODE)
  ) u_edge_sync (
    .clock (clock),
    .reset (reset),
    .sig_in(sig_in),
    .strobe(strobe)
  );

  state_t           state, state_next;
  logic [WIDTH-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] period_next;
  logic             valid_next, in_range_next, overflow_next;

  // One extra bit keeps cnt-TARGET from wrapping when cnt is below TARGET.
  logic signed [WIDTH:0] diff;
  logic        [WIDTH:0] abs_diff;
  logic                  near;

  always_comb begin
    diff     = $signed({1'b0, cnt}) - $signed({1'b0, TARGET_W});
    abs_diff = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    near     = (abs_diff <= TOL_W);
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    period_next   = period;
    valid_next    = 1'b0;
    in_range_next = in_range;
    overflow_next = overflow;
    unique case (state)
      ST_IDLE: begin
        if (strobe) begin
          state_next = ST_MEASURE;
          cnt_next   = CNT_ONE;
        end
      end
      ST_MEASURE: begin
        // A strobe on the saturating cycle still reports period=max.
        if (strobe) begin
          valid_next    = 1'b1;
          period_next   = cnt;
          in_range_next = near;
          overflow_next = 1'b0;
          cnt_next      = CNT_ONE;
        end else if (cnt == CNT_MAX) begin
          state_next    = ST_OVERFLOW;
          overflow_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      ST_OVERFLOW: begin
        if (strobe) begin
          state_next = ST_MEASURE;
          cnt_next   = CNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      period   <= '0;
      valid    <= 1'b0;
      in_range <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      period   <= period_next;
      valid    <= valid_next;
      in_range <= in_range_next;
      overflow <= overflow_next;
    end
  end

endmodule
